fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// Instruction fetch stage of the 32-bit RISC pipeline, directly upstream of the IF/ID pipeline buffer register.
// Owns the PC, issues requests to instruction memory over a req/ack handshake, and presents {valid, pc, instr} to the IF/ID register.
// Honours the same stall the hazard unit drives into that register's hold input.
// Honours redirects (branch/jump/trap) and squashes any in-flight fetch.
// PARAMETERS
// N         32            data/address width
// RESET_PC  32'h0000_0000 PC after reset
// PC_STEP   4             PC increment per fetched instruction
// PORTS
// clk          in   1  rising-edge clock
// rst_n        in   1  asynchronous active-low reset
// stall        in   1  downstream hold; if_* must not change while stall=1 and if_valid=1
// redirect     in   1  load redirect_pc, squash fetch; priority over stall and ack
// redirect_pc  in   N  target PC
// imem_req     out  1  fetch request
// imem_addr    out  N  fetch address; stable while imem_req=1 until imem_ack
// imem_ack     in   1  rdata valid this cycle; only meaningful while imem_req=1
// imem_rdata   in   N  fetched instruction
// if_valid     out  1  if_pc/if_instr hold a real instruction
// if_pc        out  N  PC of if_instr
// if_instr     out  N  instruction to IF/ID register
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, skid empty.
// - Reset outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0.
// - States: IDLE, REQ, FULL, DROP.
// - imem_req=1 in REQ and DROP, else 0.
// - imem_addr = pc in REQ and FULL; in DROP it equals the address latched at squash.
// - IDLE: -> REQ on the first clock after reset release.
// - out_free = !if_valid || !stall (output register may load this edge).
// - REQ, ack=1, out_free: if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP; stay REQ.
//   Sustained throughput: 1 instr/cycle. Latency: ack in cycle t -> if_valid=1 at t+1.
// - REQ, ack=1, !out_free: rdata/pc go to 1-entry skid, pc<=pc+PC_STEP, -> FULL. Outputs unchanged.
// - REQ, ack=0, out_free: if_valid<=0 (bubble); if_pc/if_instr may keep old values.
// - FULL: imem_req=0. When stall=0: if_* <= skid contents, skid empty, -> REQ.
// - redirect=1 (any state except IDLE): pc<=redirect_pc, if_valid<=0, skid emptied.
//   - REQ with ack=0: request already outstanding; latch old address, -> DROP.
//   - REQ with ack=1 this cycle: data discarded, stay REQ with new pc.
//   - FULL: -> REQ with new pc.
//   - DROP: -> DROP with new pc; the old outstanding request is still the one to drain.
// - DROP: keep req with latched addr until ack; discard rdata, if_valid stays 0, -> REQ at pc.
// - stall with if_valid=0 never blocks acceptance (bubble fill).
// - PC arithmetic is modulo 2^N; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
// - No combinational path from imem_ack/imem_rdata to if_* outputs; all if_* are registered.
// - Reset asserted mid-operation: immediate return to reset values; any pending ack ignored.
// TESTING
// T1 reset release, ack every cycle -> imem_addr 0,4,8,C; if_pc 0,4,8 from cycle after each ack; if_valid=1 continuous.
// T2 stall=1 for 3 cycles while ack=1 at addr 8 -> instr 8 in skid, req=0; outputs frozen at pc 4; stall=0 -> if_pc=8 next cycle, then req for C.
// T3 redirect to 0x100 while addr 0x10 outstanding (ack=0) -> req held at 0x10; its ack discarded (if_valid=0); next req at 0x100.
// T4 redirect to 0x40 in same cycle as ack for 0x20 -> 0x20 never appears on if_*; next imem_addr=0x40.
// T5 ack withheld 4 cycles with stall=0 -> if_valid=0 bubbles and imem_addr stable throughout; ack -> if_valid=1 for that pc.
// T6 rst_n low mid-FULL -> req=0, if_valid=0, pc=RESET_PC immediately; restart fetches from 0. Also redirect to 0xFFFF_FFFC -> next fetch 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage; owns the PC, fetches over req/ack and
//            feeds {valid, pc, instr} to the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic         if_valid,
    output logic [N-1:0] if_pc,
    output logic [N-1:0] if_instr
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_FULL = 2'd2;
    localparam logic [1:0] c_DROP = 2'd3;

    localparam logic [N-1:0] c_STEP = N'(PC_STEP);

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_drop_addr;
    logic [N-1:0] r_skid_pc;
    logic [N-1:0] r_skid_instr;
    logic         r_if_valid;
    logic [N-1:0] r_if_pc;
    logic [N-1:0] r_if_instr;
    logic         w_out_free;
    logic [N-1:0] w_pc_inc;

    assign w_out_free = !r_if_valid || !stall;
    assign w_pc_inc   = r_pc + c_STEP;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                w_next_state = c_REQ;
            end
            c_REQ: begin
                if (redirect) begin
                    w_next_state = imem_ack ? c_REQ : c_DROP;
                end else if (imem_ack && !w_out_free) begin
                    w_next_state = c_FULL;
                end
            end
            c_FULL: begin
                if (redirect || !stall) begin
                    w_next_state = c_REQ;
                end
            end
            c_DROP: begin
                // Once the stale request is acked there is nothing left to drain.
                if (imem_ack) begin
                    w_next_state = c_REQ;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        case (r_state)
            c_REQ: begin
                imem_req = 1'b1;
            end
            c_DROP: begin
                imem_req  = 1'b1;
                imem_addr = r_drop_addr;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, skid buffer and IF/ID output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_drop_addr  <= RESET_PC;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_instr   <= '0;
        end else begin
            case (r_state)
                c_REQ: begin
                    if (redirect) begin
                        r_pc       <= redirect_pc;
                        r_if_valid <= 1'b0;
                        if (!imem_ack) begin
                            r_drop_addr <= r_pc;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_pc_inc;
                        if (w_out_free) begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_instr <= imem_rdata;
                        end else begin
                            r_skid_pc    <= r_pc;
                            r_skid_instr <= imem_rdata;
                        end
                    end else if (w_out_free) begin
                        r_if_valid <= 1'b0;
                    end
                end
                c_FULL: begin
                    if (redirect) begin
                        r_pc       <= redirect_pc;
                        r_if_valid <= 1'b0;
                    end else if (!stall) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_skid_pc;
                        r_if_instr <= r_skid_instr;
                    end
                end
                c_DROP: begin
                    r_if_valid <= 1'b0;
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end
                end
                default: begin
                    r_if_valid <= 1'b0;
                end
            endcase
        end
    end

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int errors = 0;
    int checks = 0;

    fetch_stage #(
        .N        (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word tagged with the low half of the requested address.
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        tick();
        tick();
        chk("rst_req",    {31'd0, imem_req}, 32'd0);
        chk("rst_addr",   imem_addr,         32'h0);
        chk("rst_valid",  {31'd0, if_valid}, 32'd0);
        chk("rst_pc",     if_pc,             32'h0);
        chk("rst_instr",  if_instr,          32'h0);

        // T1: release reset, ack every cycle
        rst_n = 1'b1;
        tick();
        chk("t1_req",    {31'd0, imem_req}, 32'd1);
        chk("t1_addr0",  imem_addr,         32'h0);
        chk("t1_valid0", {31'd0, if_valid}, 32'd0);
        imem_ack = 1'b1;
        tick();
        chk("t1_ifpc0",  if_pc,             32'h0);
        chk("t1_ifv0",   {31'd0, if_valid}, 32'd1);
        chk("t1_instr0", if_instr,          32'hC0DE_0000);
        chk("t1_addr4",  imem_addr,         32'h4);
        tick();
        chk("t1_ifpc4",  if_pc,             32'h4);
        chk("t1_ifv4",   {31'd0, if_valid}, 32'd1);
        chk("t1_addr8",  imem_addr,         32'h8);

        // T2: stall 3 cycles while addr 8 is acked
        stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("t2_req0",   {31'd0, imem_req}, 32'd0);
        chk("t2_ifpc_a", if_pc,             32'h4);
        chk("t2_ifv_a",  {31'd0, if_valid}, 32'd1);
        tick();
        chk("t2_ifpc_b", if_pc,             32'h4);
        chk("t2_req_b",  {31'd0, imem_req}, 32'd0);
        tick();
        chk("t2_ifpc_c", if_pc,             32'h4);
        chk("t2_instr_c", if_instr,         32'hC0DE_0004);
        stall = 1'b0;
        tick();
        chk("t2_ifpc8",  if_pc,             32'h8);
        chk("t2_instr8", if_instr,          32'hC0DE_0008);
        chk("t2_ifv8",   {31'd0, if_valid}, 32'd1);
        chk("t2_req1",   {31'd1 & 31'd0, imem_req}, 32'd1);
        chk("t2_addrC",  imem_addr,         32'hC);

        // T5: ack withheld 4 cycles -> bubbles, address stable
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_bubble", {31'd0, if_valid}, 32'd0);
            chk("t5_addr",   imem_addr,         32'hC);
        end
        imem_ack = 1'b1;
        tick();
        chk("t5_ifv",    {31'd0, if_valid}, 32'd1);
        chk("t5_ifpc",   if_pc,             32'hC);
        chk("t5_addr10", imem_addr,         32'h10);

        // T3: redirect while 0x10 outstanding
        imem_ack    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("t3_req",    {31'd0, imem_req}, 32'd1);
        chk("t3_addr",   imem_addr,         32'h10);
        chk("t3_ifv",    {31'd0, if_valid}, 32'd0);
        tick();
        chk("t3_hold",   imem_addr,         32'h10);
        imem_ack = 1'b1;
        tick();
        chk("t3_drop",   {31'd0, if_valid}, 32'd0);
        chk("t3_addr100", imem_addr,        32'h100);
        // Stall with an empty output register must not block acceptance.
        stall = 1'b1;
        tick();
        chk("t3_ifv100", {31'd0, if_valid}, 32'd1);
        chk("t3_ifpc100", if_pc,            32'h100);
        chk("t3_addr104", imem_addr,        32'h104);

        // T4: redirect coincident with an ack
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        chk("t4_ifv_a",  {31'd0, if_valid}, 32'd0);
        chk("t4_addr20", imem_addr,         32'h20);
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("t4_ifv_b",  {31'd0, if_valid}, 32'd0);
        chk("t4_addr40", imem_addr,         32'h40);
        tick();
        chk("t4_ifpc40", if_pc,             32'h40);
        chk("t4_ifv40",  {31'd0, if_valid}, 32'd1);
        chk("t4_instr40", if_instr,         32'hC0DE_0040);

        // T6: reach FULL, then asynchronous reset mid-cycle
        tick();
        chk("t6_full_req", {31'd0, imem_req}, 32'd0);
        chk("t6_full_pc",  if_pc,             32'h40);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req",  {31'd0, imem_req}, 32'd0);
        chk("t6_rst_ifv",  {31'd0, if_valid}, 32'd0);
        chk("t6_rst_addr", imem_addr,         32'h0);
        chk("t6_rst_ifpc", if_pc,             32'h0);
        stall = 1'b0;
        tick();
        chk("t6_hold_ifv", {31'd0, if_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_restart",  imem_addr,         32'h0);
        chk("t6_req",      {31'd0, imem_req}, 32'd1);
        tick();
        chk("t6_ifpc0",    if_pc,             32'h0);
        chk("t6_ifv0",     {31'd0, if_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("t6_addr_top", imem_addr,         32'hFFFF_FFFC);
        tick();
        chk("t6_ifpc_top", if_pc,             32'hFFFF_FFFC);
        chk("t6_instr_top", if_instr,         32'hC0DE_FFFC);
        chk("t6_wrap",     imem_addr,         32'h0);
        tick();
        chk("t6_ifpc_wrap", if_pc,            32'h0);
        chk("t6_addr4",    imem_addr,         32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
